// File: rtl/and_frame_collector.sv
// Collects WIDTH bit pairs into a frame of per-pair AND results and holds the
// completed frame, plus its AND-reduction, until the consumer takes it.
module and_frame_collector #(
   parameter int WIDTH = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           IN_VALID,
   input  logic                           A,
   input  logic                           B,
   output logic                           IN_READY,
   input  logic                           OUT_READY,
   output logic                           OUT_VALID,
   output logic [WIDTH-1:0]               Y,
   output logic                           RED,
   output logic [$clog2(WIDTH+1)-1:0]     COUNT
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_HOLD    = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             red_q, red_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ov_q, ov_d;

   logic accept;
   logic consume;
   logic ab;

   assign IN_READY = (state_q == ST_COLLECT) ? 1'b1 : OUT_READY;
   assign accept   = IN_VALID & IN_READY;
   assign consume  = ov_q & OUT_READY;
   assign ab       = A & B;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      red_d   = red_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               // Decoded write keeps the index width independent of COUNT's width.
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  if (cnt_q == CW'(i)) y_d[i] = ab;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = ST_HOLD;
                  ov_d    = 1'b1;
                  red_d   = &y_d;
               end
            end
         end
         default: begin
            if (consume) begin
               y_d   = '0;
               red_d = 1'b0;
               cnt_d = '0;
               ov_d  = 1'b0;
               state_d = ST_COLLECT;
               if (accept) begin
                  // The accepted pair opens the next frame; with one pair per frame it also closes it.
                  y_d[0] = ab;
                  cnt_d  = CW'(1);
                  if (WIDTH == 1) begin
                     red_d   = ab;
                     ov_d    = 1'b1;
                     state_d = ST_HOLD;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_COLLECT;
         y_q     <= '0;
         red_q   <= 1'b0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         red_q   <= red_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
      end
   end

   assign OUT_VALID = ov_q;
   assign Y         = y_q;
   assign RED       = red_q;
   assign COUNT     = cnt_q;

endmodule

// File: tb/tb_and_frame_collector.sv
// Bench for and_frame_collector: vector table, directed corner sequences and
// random traffic checked against a queue-based frame model (WIDTH=8 and WIDTH=1).
module tb_and_frame_collector;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       iv, a, b, or8;
   logic       ir8, ov8, red8;
   logic [7:0] y8;
   logic [3:0] cnt8;

   logic       iv1, a1, b1, or1;
   logic       ir1, ov1, red1;
   logic [0:0] y1;
   logic [0:0] cnt1;

   and_frame_collector #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST(rst), .IN_VALID(iv), .A(a), .B(b), .IN_READY(ir8),
      .OUT_READY(or8), .OUT_VALID(ov8), .Y(y8), .RED(red8), .COUNT(cnt8)
   );

   and_frame_collector #(.WIDTH(1)) dut1 (
      .CLK(clk), .RST(rst), .IN_VALID(iv1), .A(a1), .B(b1), .IN_READY(ir1),
      .OUT_READY(or1), .OUT_VALID(ov1), .Y(y1), .RED(red1), .COUNT(cnt1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: pending frame bits in a queue plus a held result slot.
   bit         m_q[$];
   bit         m_held;
   logic [7:0] m_y_held;

   function automatic logic [7:0] q_pack();
      logic [7:0] v = '0;
      foreach (m_q[i]) v[i] = m_q[i];
      return v;
   endfunction

   function automatic logic m_rdy(input logic o);
      return !m_held || o;
   endfunction

   task automatic m_clear();
      m_q.delete();
      m_held   = 1'b0;
      m_y_held = '0;
   endtask

   task automatic chk_model();
      chk("model_y",     y8,   m_held ? m_y_held : q_pack());
      chk("model_count", cnt8, m_held ? W : m_q.size());
      chk("model_valid", ov8,  m_held);
      chk("model_red",   red8, m_held && (&m_y_held));
      chk("model_ready", ir8,  m_rdy(or8));
   endtask

   task automatic step8(input logic v, input logic ai, input logic bi, input logic o);
      logic acc, con;
      @(negedge clk);
      iv = v; a = ai; b = bi; or8 = o;
      #1;
      chk("in_ready_pre", ir8, m_rdy(o));
      @(posedge clk);
      acc = v && m_rdy(o);
      con = m_held && o;
      if (con) m_held = 1'b0;
      if (acc) begin
         m_q.push_back(ai & bi);
         if (m_q.size() == W) begin
            m_y_held = q_pack();
            m_held   = 1'b1;
            m_q.delete();
         end
      end
      #1;
   endtask

   task automatic step1(input logic v, input logic ai, input logic bi, input logic o);
      @(negedge clk);
      iv1 = v; a1 = ai; b1 = bi; or1 = o;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      m_clear();
      for (int i = 0; i < cycles; i++) begin
         iv = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
         @(posedge clk);
         #1;
         chk("rst_valid", ov8, 1'b0);
         chk("rst_y", y8, 8'h00);
         chk("rst_count", cnt8, 4'd0);
         chk("rst_ready", ir8, 1'b1);
         @(negedge clk);
      end
      rst = 1'b0;
      iv = 1'b0; or8 = 1'b0;
   endtask

   typedef struct {
      logic       iv, a, b, o;
      logic [7:0] y;
      logic [3:0] cnt;
      logic       ov, red, rdy;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic ai, input logic bi, input logic o,
                               input logic [7:0] y, input logic [3:0] c,
                               input logic ovv, input logic rd, input logic ry);
      vec_t t;
      t.iv = v; t.a = ai; t.b = bi; t.o = o;
      t.y = y; t.cnt = c; t.ov = ovv; t.red = rd; t.rdy = ry;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [7:0] pat_a, pat_b, exp_y;
      int results;
      logic ab;

      rst = 1'b1; iv = 0; a = 0; b = 0; or8 = 0;
      iv1 = 0; a1 = 0; b1 = 0; or1 = 0;
      m_clear();

      // Full frame, consume, mixed data, consume-with-accept.
      tbl.push_back(mk(1,1,1,0, 8'h01, 1, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h03, 2, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h07, 3, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h0F, 4, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h1F, 5, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h3F, 6, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h7F, 7, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'hFF, 8, 1, 1, 0));
      tbl.push_back(mk(1,1,1,0, 8'hFF, 8, 1, 1, 0));
      tbl.push_back(mk(0,0,0,1, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h01, 1, 0, 0, 1));
      tbl.push_back(mk(1,1,0,0, 8'h01, 2, 0, 0, 1));
      tbl.push_back(mk(1,0,1,0, 8'h01, 3, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h09, 4, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h19, 5, 0, 0, 1));
      tbl.push_back(mk(1,0,0,0, 8'h19, 6, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'h59, 7, 0, 0, 1));
      tbl.push_back(mk(1,1,1,0, 8'hD9, 8, 1, 0, 0));
      tbl.push_back(mk(1,1,1,1, 8'h01, 1, 0, 0, 1));

      do_reset(6);
      foreach (tbl[i]) begin
         step8(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].o);
         chk($sformatf("tbl%0d_y", i),     y8,   tbl[i].y);
         chk($sformatf("tbl%0d_count", i), cnt8, tbl[i].cnt);
         chk($sformatf("tbl%0d_valid", i), ov8,  tbl[i].ov);
         chk($sformatf("tbl%0d_red", i),   red8, tbl[i].red);
         chk($sformatf("tbl%0d_ready", i), ir8,  tbl[i].rdy);
      end

      // Back-to-back frames at full throughput.
      do_reset(2);
      results = 0;
      for (int k = 1; k <= 24; k++) begin
         step8(1, 1, 1, 1);
         if (ov8) results++;
         chk("b2b_valid", ov8, (k % 8) == 0);
         chk("b2b_count", cnt8, ((k % 8) == 0) ? 8 : (k % 8));
      end
      chk("b2b_results", results, 3);

      // Asynchronous reset mid-frame discards the partial frame.
      do_reset(2);
      for (int k = 0; k < 5; k++) step8(1, 1, 1, 0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_y", y8, 8'h00);
      chk("async_rst_count", cnt8, 4'd0);
      chk("async_rst_valid", ov8, 1'b0);
      chk("async_rst_ready", ir8, 1'b1);
      m_clear();
      #1 rst = 1'b0;
      for (int k = 0; k < 8; k++) step8(1, 1, (k != 3), 0);
      chk("post_rst_y", y8, 8'hF7);
      chk("post_rst_valid", ov8, 1'b1);
      chk("post_rst_red", red8, 1'b0);
      step8(0, 0, 0, 1);
      step8(0, 0, 0, 1);
      chk("post_rst_no_extra", ov8, 1'b0);

      // Same data with and without input gaps.
      pat_a = 8'($urandom); pat_b = 8'($urandom);
      exp_y = pat_a & pat_b;
      for (int k = 0; k < 8; k++) step8(1, pat_a[k], pat_b[k], 0);
      chk("gapless_y", y8, exp_y);
      step8(0, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            step8(0, 1'($urandom), 1'($urandom), 0);
         step8(1, pat_a[k], pat_b[k], 0);
      end
      chk("gapped_y", y8, exp_y);
      chk("gapped_red", red8, &exp_y);
      step8(0, 0, 0, 1);

      // Random traffic against the model, with occasional async resets.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 59) == 0) begin
            #1 rst = 1'b1;
            m_clear();
            #1 rst = 1'b0;
         end
         step8($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom));
         chk_model();
      end
      iv = 1'b0;

      // WIDTH=1: alternating valid, then continuous, then a held result.
      do_reset(2);
      for (int k = 0; k < 8; k++) begin
         logic ra, rb;
         ra = 1'($urandom); rb = 1'($urandom); ab = ra & rb;
         step1((k % 2) == 0, ra, rb, 1);
         if ((k % 2) == 0) begin
            chk("w1_alt_valid", ov1, 1'b1);
            chk("w1_alt_y", y1, ab);
            chk("w1_alt_red", red1, ab);
            chk("w1_alt_count", cnt1, 1'b1);
         end else begin
            chk("w1_gap_valid", ov1, 1'b0);
            chk("w1_gap_y", y1, 1'b0);
            chk("w1_gap_count", cnt1, 1'b0);
         end
      end
      for (int k = 0; k < 6; k++) begin
         logic ra, rb;
         ra = 1'($urandom); rb = (k < 2) ? 1'b1 : 1'($urandom); ab = ra & rb;
         if (k == 0) ra = 1'b1;
         ab = ra & rb;
         step1(1, ra, rb, 1);
         chk("w1_cont_valid", ov1, 1'b1);
         chk("w1_cont_y", y1, ab);
         chk("w1_cont_red", red1, ab);
      end
      step1(1, ~ab, 1'b1, 0);
      chk("w1_hold_y", y1, ab);
      chk("w1_hold_valid", ov1, 1'b1);
      chk("w1_hold_ready", ir1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
